// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and the
// synchronizer depth used by edge_sync.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/period_meter_if.sv
// Request/result handshake between a consumer (master) and the period
// meter (slave). N is the width of the period result.
interface period_meter_if #(
  parameter int N = 16
) ();

  logic         start;
  logic         ack;
  logic         busy;
  logic         valid;
  logic [N-1:0] period;
  logic         ovf;

  modport master (
    output start, ack,
    input  busy, valid, period, ovf
  );

  modport slave (
    input  start, ack,
    output busy, valid, period, ovf
  );

endinterface

// File: rtl/period_meter_edge_sync.sv
// edge_sync: brings sig_in into the clk domain through a SYNC_DEPTH-flop
// synchronizer and emits a one-cycle pulse on each rising edge.
// With PERIOD_METER_GLITCH_FILTER_EN defined, the synchronized level must be
// stable for two consecutive samples before the filtered level follows it,
// so single-cycle pulses are rejected at the cost of two extra cycles of
// edge latency.
module edge_sync
  import period_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_b,
  input  logic sig_in,
  output logic rise
);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  lvl;
  logic                  prev_q, prev_d;

  // Shift the raw input through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], sig_in};
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) sync_q <= '0;
    else        sync_q <= sync_d;
  end

`ifdef PERIOD_METER_GLITCH_FILTER_EN
  logic hist_q, hist_d;
  logic filt_q, filt_d;

  // Follow the synchronized level only once two consecutive samples agree.
  always_comb begin
    hist_d = sync_q[SYNC_DEPTH-1];
    filt_d = filt_q;
    if (sync_q[SYNC_DEPTH-1] == hist_q) filt_d = hist_q;
  end

  // Filter history and output flops.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hist_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[SYNC_DEPTH-1];
`endif

  // Remember the previous level for edge detection.
  always_comb begin
    prev_d = lvl;
    rise   = lvl & ~prev_q;
  end

  // Previous-level flop.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

endmodule

// File: rtl/period_meter.sv
// period_meter: measures the period of sig_in in clk cycles between two
// consecutive rising edges after an armed start. The count saturates at
// 2^N-1 and flags ovf instead of wrapping. The result is held with valid
// until acknowledged. Optional input glitch filter: PERIOD_METER_GLITCH_FILTER_EN.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                sig_in,
  period_meter_if.slave       bus
);

  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

  logic         rise;
  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] period_q, period_d;
  logic         ovf_q, ovf_d;

  edge_sync u_edge_sync (
    .clk    (clk),
    .rst_b  (rst_b),
    .sig_in (sig_in),
    .rise   (rise)
  );

  // Next-state, counter and result update.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = ARM;
      end
      ARM: begin
        if (rise) begin
          count_d = CNT_ONE;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (rise) begin
          period_d = count_q;
          ovf_d    = 1'b0;
          state_d  = DONE;
        end else if (count_q == CNT_MAX) begin
          period_d = CNT_MAX;
          ovf_d    = 1'b1;
          state_d  = DONE;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      DONE: begin
        // ack wins over any start seen in the same cycle.
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and result registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = (state_q == ARM) || (state_q == COUNT);
  assign bus.valid  = (state_q == DONE);
  assign bus.period = period_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a 16-bit instance for the main flows and
// a 4-bit instance for saturation. sig_in for the 16-bit instance comes from
// a clk-synchronous waveform generator with an optional one-cycle glitch.
module tb_period_meter;

  logic clk;
  logic rst_b;
  logic sig16;
  logic sig4;

  int tests;
  int fails;

  // waveform generator controls
  bit gen_en;
  int gen_p;
  int gen_h;
  int gen_g;
  int ph;

  period_meter_if #(.N(16)) if16 ();
  period_meter_if #(.N(4))  if4 ();

  period_meter #(.N(16)) dut16 (
    .clk    (clk),
    .rst_b  (rst_b),
    .sig_in (sig16),
    .bus    (if16.slave)
  );

  period_meter #(.N(4)) dut4 (
    .clk    (clk),
    .rst_b  (rst_b),
    .sig_in (sig4),
    .bus    (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Periodic sig16: high for gen_h of every gen_p cycles, plus a one-cycle
  // pulse at phase gen_g when gen_g is within the period.
  always @(negedge clk) begin
    if (gen_en) begin
      ph    = (ph + 1 >= gen_p) ? 0 : ph + 1;
      sig16 = (ph < gen_h) || (ph == gen_g);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic gen_set(input int p, input int h, input int g);
    gen_en = 1'b0;
    sig16  = 1'b0;
    repeat (4) @(negedge clk);
    gen_p  = p;
    gen_h  = h;
    gen_g  = g;
    ph     = p - 1;
    gen_en = 1'b1;
  endtask

  task automatic start16();
    if16.start = 1'b1;
    @(negedge clk);
    if16.start = 1'b0;
  endtask

  task automatic ack16();
    if16.ack = 1'b1;
    @(negedge clk);
    if16.ack = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int which, input int lim);
    int n;
    n = 0;
    while (((which == 4) ? if4.valid : if16.valid) !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (which == 4) ? if4.valid : if16.valid, 1);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    gen_en    = 1'b0;
    gen_p     = 8;
    gen_h     = 4;
    gen_g     = -1;
    ph        = 0;
    sig16     = 1'b0;
    sig4      = 1'b0;
    if16.start = 1'b0;
    if16.ack   = 1'b0;
    if4.start  = 1'b0;
    if4.ack    = 1'b0;
    rst_b     = 1'b1;
    #2 rst_b  = 1'b0;
    #1;
    // reset state
    chk("rst_busy",   if16.busy, 0);
    chk("rst_valid",  if16.valid, 0);
    chk("rst_period", if16.period, 0);
    chk("rst_ovf",    if16.ovf, 0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;

    // period 8, 4 high / 4 low
    gen_set(8, 4, -1);
    start16();
    chk("p8_busy_after_start", if16.busy, 1);
    chk("p8_valid_after_start", if16.valid, 0);
    wait_valid("p8_valid", 16, 200);
    chk("p8_period", if16.period, 8);
    chk("p8_ovf",    if16.ovf, 0);
    chk("p8_busy_done", if16.busy, 0);
    // result held without ack
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid",  if16.valid, 1);
      chk("hold_period", if16.period, 8);
      chk("hold_ovf",    if16.ovf, 0);
    end
    ack16();
    chk("p8_valid_after_ack",  if16.valid, 0);
    chk("p8_period_retained",  if16.period, 8);
    // ack while idle does nothing
    ack16();
    chk("idle_ack_valid",  if16.valid, 0);
    chk("idle_ack_busy",   if16.busy, 0);
    chk("idle_ack_period", if16.period, 8);

    // minimum period
`ifdef PERIOD_METER_GLITCH_FILTER_EN
    gen_set(4, 2, -1);
    start16();
    wait_valid("pmin_valid", 16, 200);
    chk("pmin_period", if16.period, 4);
`else
    gen_set(2, 1, -1);
    start16();
    wait_valid("pmin_valid", 16, 200);
    chk("pmin_period", if16.period, 2);
`endif
    ack16();

    // second start while busy, then start+ack together in DONE
    gen_set(12, 6, -1);
    start16();
    start16();
    chk("p12_busy_restart", if16.busy, 1);
    wait_valid("p12_valid", 16, 200);
    chk("p12_period", if16.period, 12);
    if16.start = 1'b1;
    if16.ack   = 1'b1;
    @(negedge clk);
    if16.start = 1'b0;
    if16.ack   = 1'b0;
    chk("start_ack_valid", if16.valid, 0);
    chk("start_ack_busy",  if16.busy, 0);
    repeat (3) @(negedge clk);
    chk("start_ack_busy_later", if16.busy, 0);

    // 4-bit saturation: one edge to arm, then no further edge
    sig4 = 1'b1;
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    sig4 = 1'b1;
    repeat (3) @(negedge clk);
    sig4 = 1'b0;
    wait_valid("sat_valid", 4, 100);
    chk("sat_period", if4.period, 15);
    chk("sat_ovf",    if4.ovf, 1);
    chk("sat_busy",   if4.busy, 0);
    if4.ack = 1'b1;
    @(negedge clk);
    if4.ack = 1'b0;
    chk("sat_valid_after_ack", if4.valid, 0);
    chk("sat_ovf_retained",    if4.ovf, 1);

    // period 10 with a one-cycle glitch in the low phase
    gen_set(10, 5, 7);
    start16();
    wait_valid("glitch_valid", 16, 200);
`ifdef PERIOD_METER_GLITCH_FILTER_EN
    chk("glitch_filtered_period", if16.period, 10);
`else
    chk("glitch_raw_period_lt10", (if16.period < 16'd10) ? 32'd1 : 32'd0, 1);
`endif
    ack16();

    // reset in the middle of a measurement
    gen_set(20, 10, -1);
    start16();
    repeat (12) @(negedge clk);
    chk("midcount_busy", if16.busy, 1);
    rst_b = 1'b0;
    #1;
    chk("midrst_busy",   if16.busy, 0);
    chk("midrst_valid",  if16.valid, 0);
    chk("midrst_period", if16.period, 0);
    chk("midrst_ovf",    if16.ovf, 0);
    chk("midrst_period4", if4.period, 0);
    gen_set(6, 3, -1);
    rst_b = 1'b1;
    start16();
    chk("post_rst_busy", if16.busy, 1);
    wait_valid("p6_valid", 16, 200);
    chk("p6_period", if16.period, 6);
    chk("p6_ovf",    if16.ovf, 0);
    ack16();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter N, default 16: width of the period count and result.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 sig_in  input  1  measured signal (e.g. a divided clock), asynchronous to clk.
REQ-005 start  input  1  one-cycle request to arm a measurement.
REQ-006 ack  input  1  consumer acknowledge of the current result.
REQ-007 busy  output  1  high from accepted start until the result is posted.
REQ-008 valid  output  1  high while period/ovf hold an unacknowledged result.
REQ-009 period  output  N  measured sig_in period, in clk cycles.
REQ-010 ovf  output  1  measurement saturated; period is invalid.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer; a rising edge is one cycle where the synchronized value is 1 and its previous value was 0.
REQ-012 FSM states SHALL be IDLE, ARM, COUNT, DONE.
REQ-013 IDLE: start=1 -> ARM, busy=1 next cycle; start in any other state is ignored.
REQ-014 ARM: first detected edge clears the count to 1 -> COUNT.
REQ-015 COUNT: count increments by 1 each cycle without an edge; on the next edge, period <= count, ovf <= 0 -> DONE.
REQ-016 The result SHALL equal the number of clk cycles between the two detected edges: a sig_in period of P clk cycles yields period=P.
REQ-017 If count reaches 2^N-1 in COUNT with no edge: period <= all ones, ovf <= 1 -> DONE. The counter SHALL NOT wrap.
REQ-018 valid SHALL rise one cycle after the terminating edge or saturation; busy SHALL fall in the same cycle.
REQ-019 DONE: valid, period and ovf SHALL hold until ack=1; then -> IDLE, valid=0 next cycle, period/ovf retained.
REQ-020 ack outside DONE SHALL have no effect.
REQ-021 start and ack in the same DONE cycle: ack is honoured and start is dropped.
REQ-022 An edge in the same cycle the FSM enters ARM SHALL NOT be counted.
REQ-023 Minimum measurable period is 2; edges closer than the synchronizer resolves are undefined.

Reset
REQ-024 rst_b=0 SHALL immediately force state=IDLE, count=0, period=0, ovf=0, valid=0, busy=0, and clear the synchronizer flops.
REQ-025 Reset mid-measurement SHALL abandon it with no result posted.
REQ-026 The first start SHALL be accepted on the first clk edge after rst_b deasserts.

Configuration
REQ-027 Macro PERIOD_METER_GLITCH_FILTER_EN.
REQ-028 Defined: the synchronized sig_in SHALL pass a filter that changes its output only after the input is stable for 2 consecutive cycles. Pulses of 1 cycle are rejected. Edge detection latency is +2 cycles, and period values are unchanged for clean inputs.
REQ-029 Undefined: no filter; behaviour per REQ-011.

Structure
REQ-030 Package period_meter_pkg SHALL hold the FSM state encoding (2 bits: IDLE=0, ARM=1, COUNT=2, DONE=3) and the synchronizer depth constant (2).
REQ-031 Sub-module edge_sync SHALL contain the synchronizer, the optional filter and the rising-edge detector; it outputs a one-cycle pulse rise.
REQ-032 Expected RTL size is 120-300 lines in total.

Verification
REQ-033 sig_in period 8 clk (4 high/4 low), start pulse -> valid with period=8, ovf=0; ack -> valid=0 next cycle.
REQ-034 N=4, sig_in held low after start -> saturation at 15: period=15, ovf=1, valid=1.
REQ-035 Second start while busy, then start+ack together in DONE -> no re-arm; FSM returns to IDLE and busy stays 0.
REQ-036 rst_b pulsed low mid-COUNT -> all outputs 0 at once; a new start with period 6 -> period=6.
REQ-037 PERIOD_METER_GLITCH_FILTER_EN defined, period 10 with a 1-cycle glitch high inside the low phase -> period=10. Without the macro, the same stimulus -> period less than 10.
REQ-038 valid held 5 cycles without ack -> period/ovf stable throughout; ack issued in IDLE -> no effect.
